ram_io_responder: RTL and testbench

RAM_IO_RESPONDER -- requirements
Module: ram_io_responder

---
 rtl/ram_io_responder.sv | 133 +++++++++++++
 tb/tb_ram_io_responder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ram_io_responder.sv
// ram_io_responder: byte-wide RAM plus a two-register I/O window.
// The I/O window is a_in[17:16] == 2'b11, with these registers:
//   +0x0 data (TX push on write, RX pop on read)
//   +0x4 status on read, end-of-simulation flag on write
// TX and RX are small circular FIFOs facing an external valid/ready byte stream.
// When rdy is low, every piece of state holds.
module ram_io_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] a_in,
  input  logic        rw_in,
  input  logic [7:0]  d_in,
  output logic [7:0]  d_out,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        tx_overflow,
  output logic        sim_end
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ALMOST_CNT = CW'(FIFO_DEPTH - 1);

  logic [7:0] ram [0:(1 << ADDR_WIDTH) - 1];
  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [7:0] rx_mem [FIFO_DEPTH];

  logic [PW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [CW-1:0] tx_count, rx_count;

  logic [ADDR_WIDTH-1:0] ram_idx;
  logic io_sel, io_data, io_stat;
  logic tx_full, rx_nonempty;
  logic wr_tx, tx_push, tx_pop, tx_drop;
  logic rx_push, rx_pop;
  logic unused_a;

  assign ram_idx  = a_in[ADDR_WIDTH-1:0];
  assign io_sel   = (a_in[17:16] == 2'b11);
  assign io_data  = io_sel && (a_in[15:0] == 16'h0000);
  assign io_stat  = io_sel && (a_in[15:0] == 16'h0004);
  assign unused_a = ^a_in[31:18];

  assign tx_full        = (tx_count == FULL_CNT);
  assign rx_nonempty    = (rx_count != '0);
  assign io_buffer_full = (tx_count >= ALMOST_CNT);
  assign tx_valid       = rdy && (tx_count != '0);
  assign rx_ready       = rdy && (rx_count != FULL_CNT);
  assign tx_data        = tx_mem[tx_rd_ptr];

  // A push into a full TX FIFO is accepted only when a pop frees a slot in the same cycle.
  assign tx_pop  = tx_valid && tx_ready;
  assign wr_tx   = rdy && rw_in && io_data;
  assign tx_push = wr_tx && (!tx_full || tx_pop);
  assign tx_drop = wr_tx && tx_full && !tx_pop;
  assign rx_push = rx_valid && rx_ready;
  assign rx_pop  = rdy && !rw_in && io_data && rx_nonempty;

  // RAM and FIFO storage are not reset; only the pointers and counts are.
  always_ff @(posedge clk) begin
    if (rdy && rw_in && !io_sel) ram[ram_idx] <= d_in;
    if (tx_push) tx_mem[tx_wr_ptr] <= d_in;
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
  end

  // TX FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + CW'(1);
        2'b01:   tx_count <= tx_count - CW'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + CW'(1);
        2'b01:   rx_count <= rx_count - CW'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  // Registered read data; writes and paused cycles leave d_out untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_out <= 8'h00;
    end else if (rdy && !rw_in) begin
      if (!io_sel)      d_out <= ram[ram_idx];
      else if (io_data) d_out <= rx_nonempty ? rx_mem[rx_rd_ptr] : 8'h00;
      else if (io_stat) d_out <= {6'b0, rx_nonempty, tx_full};
      else              d_out <= 8'h00;
    end
  end

  // Sticky flags, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_overflow <= 1'b0;
      sim_end     <= 1'b0;
    end else begin
      if (tx_drop) tx_overflow <= 1'b1;
      if (rdy && rw_in && io_stat) sim_end <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_io_responder.sv
// Scoreboard bench for ram_io_responder: read expectations, TX bytes and RX bytes are
// queued when stimulus is driven and consumed when the DUT produces them.
module tb_ram_io_responder;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst, rdy, rw_in, tx_ready, rx_valid;
  logic [31:0] a_in;
  logic [7:0]  d_in, d_out, tx_data, rx_data;
  logic        io_buffer_full, tx_valid, rx_ready, tx_overflow, sim_end;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] rd_q[$];
  logic exp_ovf = 1'b0;
  logic exp_end = 1'b0;

  ram_io_responder #(.ADDR_WIDTH(17), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .a_in(a_in), .rw_in(rw_in), .d_in(d_in),
    .d_out(d_out), .io_buffer_full(io_buffer_full), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .tx_overflow(tx_overflow),
    .sim_end(sim_end)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One access cycle: drive at negedge, check handshakes, clock, check flags.
  task automatic step(input logic [31:0] a, input logic rw, input logic [7:0] d);
    a_in = a; rw_in = rw; d_in = d;
    #1;
    chk("tx_valid", tx_valid, rdy && (tx_q.size() != 0));
    chk("rx_ready", rx_ready, rdy && (rx_q.size() < DEPTH));
    chk("io_buffer_full", io_buffer_full, tx_q.size() >= DEPTH - 1);
    if (tx_valid && tx_ready) begin
      if (tx_q.size() == 0) chk("tx_pop_empty", tx_valid, 0);
      else chk("tx_data", tx_data, tx_q.pop_front());
    end
    if (rdy && rx_valid && rx_q.size() < DEPTH) rx_q.push_back(rx_data);
    @(posedge clk);
    @(negedge clk);
    chk("tx_overflow", tx_overflow, exp_ovf);
    chk("sim_end", sim_end, exp_end);
  endtask

  task automatic rd(input logic [31:0] a, input logic [7:0] exp);
    rd_q.push_back(exp);
    step(a, 1'b0, 8'h00);
    chk("d_out", d_out, rd_q.pop_front());
  endtask

  task automatic rd_rx();
    logic had;
    logic [7:0] e;
    had = (rx_q.size() != 0);
    e = had ? rx_q[0] : 8'h00;
    rd(32'h30000, e);
    if (had) void'(rx_q.pop_front());
  endtask

  task automatic rd_stat();
    logic [7:0] e;
    e = {6'b0, rx_q.size() != 0, tx_q.size() == DEPTH};
    rd(32'h30004, e);
  endtask

  task automatic wr_tx(input logic [7:0] d);
    logic full, popping;
    full = (tx_q.size() == DEPTH);
    popping = rdy && tx_ready && (tx_q.size() != 0);
    if (rdy && full && !popping) exp_ovf = 1'b1;
    step(32'h30000, 1'b1, d);
    if (rdy && (!full || popping)) tx_q.push_back(d);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; a_in = 0; rw_in = 0; d_in = 0;
    tx_ready = 0; rx_valid = 0; rx_data = 0;
    #12;
    chk("rst_d_out", d_out, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_io_buffer_full", io_buffer_full, 0);
    chk("rst_tx_overflow", tx_overflow, 0);
    chk("rst_sim_end", sim_end, 0);
    @(negedge clk);
    rst = 1'b0;

    // RAM write/read, latency, repeated reads, top address, decode
    step(32'h10, 1'b1, 8'hA5);
    chk("d_out_on_write", d_out, 0);
    rd(32'h10, 8'hA5);
    rd(32'h10, 8'hA5);
    step(32'h1FFFF, 1'b1, 8'h3C);
    rd(32'h1FFFF, 8'h3C);
    rd(32'h10, 8'hA5);
    step(32'h10010, 1'b1, 8'h66);
    step(32'h30010, 1'b1, 8'h77);
    rd(32'h10010, 8'h66);
    rd(32'h30010, 8'h00);
    step(32'h10000, 1'b1, 8'h42);
    rd_stat();

    // TX fill, almost-full, full, push+pop at full, overflow
    tx_ready = 0;
    for (int i = 1; i <= 8; i++) begin
      wr_tx(8'(8'h11 * i));
      if (i == 4) chk("tx_head", tx_data, 8'h11);
    end
    rd_stat();
    tx_ready = 1;
    wr_tx(8'h99);
    tx_ready = 0;
    rd_stat();
    wr_tx(8'hAA);
    rd(32'h10000, 8'h42);
    tx_ready = 1;
    for (int i = 0; i < 20 && tx_q.size() != 0; i++) step(32'h0, 1'b0, 8'h00);
    chk("tx_drain_left", tx_q.size(), 0);
    tx_ready = 0;

    // RX single byte, then empty read with no second pop
    rx_valid = 1; rx_data = 8'h5A;
    step(32'h0, 1'b0, 8'h00);
    rx_valid = 0;
    rd_stat();
    rd_rx();
    rd_rx();
    rd_stat();

    // RX fill past capacity, then drain one past empty
    rx_valid = 1;
    for (int i = 0; i < 10; i++) begin
      rx_data = 8'(8'hC0 + i);
      step(32'h0, 1'b0, 8'h00);
    end
    rx_valid = 0;
    rd_stat();
    for (int i = 0; i < 9; i++) rd_rx();

    // Pause: nothing moves while rdy is low
    step(32'h20, 1'b1, 8'h12);
    rd(32'h20, 8'h12);
    wr_tx(8'h3E);
    rdy = 0; tx_ready = 1; rx_valid = 1; rx_data = 8'h99;
    step(32'h20, 1'b1, 8'hEE);
    step(32'h30004, 1'b1, 8'h00);
    wr_tx(8'h5F);
    rd(32'h10, 8'h12);
    rdy = 1; tx_ready = 0; rx_valid = 0;
    rd(32'h20, 8'h12);
    chk("tx_head_after_pause", tx_data, 8'h3E);
    rd_stat();

    // End flag, then asynchronous reset in mid-cycle
    exp_end = 1'b1;
    step(32'h30004, 1'b1, 8'h00);
    #2 rst = 1'b1;
    #1;
    chk("arst_sim_end", sim_end, 0);
    chk("arst_tx_valid", tx_valid, 0);
    chk("arst_d_out", d_out, 0);
    chk("arst_tx_overflow", tx_overflow, 0);
    tx_q.delete(); rx_q.delete();
    exp_ovf = 1'b0; exp_end = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rd_stat();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
